// File: rtl/disp_mux_scan.sv
// Four-digit seven-segment scan multiplexer: advances one digit per rising edge of clkd,
// with a BLANK_CYC all-off gap on each switch. Optional macro: DISP_LEADING_ZERO_BLANK_EN.
module disp_mux_scan #(
    parameter int BLANK_CYC = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clkd,
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    input  logic [3:0] blank,
    input  logic [3:0] dp_en,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    typedef enum logic {
        ST_SHOW  = 1'b0,
        ST_BLANK = 1'b1
    } state_t;

    localparam logic [3:0] BCNT_LAST = 4'(BLANK_CYC - 1);

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        s = 7'h7F;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    logic       r_clkd_q;
    state_t     r_state;
    logic [1:0] r_idx;
    logic [3:0] r_bcnt;
    logic [3:0] r_an;
    logic [6:0] r_seg;
    logic       r_dp;

    logic       w_tick;
    logic [3:0] w_dig [4];
    logic [6:0] w_hex [4];
    logic [3:0] w_dark;

    assign w_tick   = clkd & ~r_clkd_q;
    assign w_dig[0] = d0;
    assign w_dig[1] = d1;
    assign w_dig[2] = d2;
    assign w_dig[3] = d3;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_hex
            assign w_hex[gi] = hex7(w_dig[gi]);
        end
    endgenerate

`ifdef DISP_LEADING_ZERO_BLANK_EN
    // w_upper[i]: every digit above i is zero or blanked, so a zero at i is "leading".
    logic [3:1] w_upper;
    logic [3:2] w_clr;
    logic [3:0] w_lz;

    assign w_upper[3] = 1'b1;
    assign w_lz[0]    = 1'b0;
    generate
        for (genvar gi = 2; gi < 4; gi++) begin : g_clr
            assign w_clr[gi] = (w_dig[gi] == 4'h0) | blank[gi];
        end
        for (genvar gi = 1; gi < 3; gi++) begin : g_upper
            assign w_upper[gi] = w_upper[gi+1] & w_clr[gi+1];
        end
        for (genvar gi = 1; gi < 4; gi++) begin : g_lz
            assign w_lz[gi] = (w_dig[gi] == 4'h0) & w_upper[gi];
        end
    endgenerate

    assign w_dark = blank | w_lz;
`else
    assign w_dark = blank;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clkd_q <= 1'b0;
            r_state  <= ST_SHOW;
            r_idx    <= 2'd0;
            r_bcnt   <= 4'd0;
            r_an     <= 4'b1111;
            r_seg    <= 7'h7F;
            r_dp     <= 1'b1;
        end else begin
            r_clkd_q <= clkd;

            // Ticks arriving during BLANK are simply ignored.
            case (r_state)
                ST_SHOW: begin
                    if (w_tick) begin
                        r_state <= ST_BLANK;
                        r_bcnt  <= 4'd0;
                    end
                end
                ST_BLANK: begin
                    if (r_bcnt == BCNT_LAST) begin
                        r_state <= ST_SHOW;
                        r_idx   <= r_idx + 2'd1;
                    end else begin
                        r_bcnt <= r_bcnt + 4'd1;
                    end
                end
                default: r_state <= ST_SHOW;
            endcase

            if (r_state == ST_SHOW && !w_dark[r_idx]) begin
                r_an  <= ~(4'b0001 << r_idx);
                r_seg <= w_hex[r_idx];
                r_dp  <= ~dp_en[r_idx];
            end else begin
                r_an  <= 4'b1111;
                r_seg <= 7'h7F;
                r_dp  <= 1'b1;
            end
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule
